// File: rtl/scaler_h_step_ctrl.sv
// Horizontal scaler configuration controller: computes the 4.12 scale step
// with a sequential restoring divider, applies it on the next frame boundary
// and checks output line lengths against the active output width.
module scaler_h_step_ctrl #(
  parameter int unsigned W_WIDTH    = 12,
  parameter int unsigned FRAC_BITS  = 12,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W_WIDTH-1:0]    cfg_in_w,
  input  logic [W_WIDTH-1:0]    cfg_out_w,
  input  logic                  cfg_wr,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  vs_i,
  input  logic                  de_mon,
  input  logic                  hs_mon,
  output logic [STEP_WIDTH-1:0] scale_step,
  output logic                  step_upd,
  output logic                  line_err
);

  localparam int unsigned DIV_W  = W_WIDTH + FRAC_BITS;
  localparam int unsigned ITER_W = $clog2(DIV_W);
  localparam int unsigned CNT_W  = W_WIDTH + 1;

  localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1) << FRAC_BITS;
  localparam logic [STEP_WIDTH-1:0] STEP_MAX = {STEP_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [W_WIDTH-1:0]    out_w_q, out_w_d;
  logic [DIV_W-1:0]      dq_q, dq_d;
  logic [W_WIDTH-1:0]    rem_q, rem_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [STEP_WIDTH-1:0] result_q, result_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [W_WIDTH-1:0]    act_w_q, act_w_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  upd_q, upd_d;
  logic                  vs_d_q, vs_d_d;
  logic                  hs_d_q, hs_d_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lerr_q, lerr_d;

  logic [W_WIDTH:0]      rem_sh;
  logic [W_WIDTH:0]      rem_sub;
  logic                  q_bit;
  logic [DIV_W-1:0]      quo_next;
  logic [W_WIDTH-1:0]    rem_next;
  logic                  vs_rise;
  logic                  hs_rise;

  // One restoring-division step: dividend bits shift out of dq while quotient bits shift in
  always_comb begin
    rem_sh   = {rem_q, dq_q[DIV_W-1]};
    rem_sub  = rem_sh - {1'b0, out_w_q};
    q_bit    = (rem_sh >= {1'b0, out_w_q});
    quo_next = {dq_q[DIV_W-2:0], q_bit};
    rem_next = q_bit ? rem_sub[W_WIDTH-1:0] : rem_sh[W_WIDTH-1:0];
    vs_rise  = vs_i & ~vs_d_q;
    hs_rise  = hs_mon & ~hs_d_q;
  end

  // Configuration FSM: capture, divide, hold until frame boundary
  always_comb begin
    state_d  = state_q;
    out_w_d  = out_w_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    result_d = result_q;
    step_d   = step_q;
    act_w_d  = act_w_q;
    busy_d   = busy_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_wr) begin
          out_w_d = cfg_out_w;
          dq_d    = {cfg_in_w, {FRAC_BITS{1'b0}}};
          rem_d   = '0;
          iter_d  = '0;
          if (cfg_out_w == '0) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        dq_d   = quo_next;
        rem_d  = rem_next;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(DIV_W - 1)) begin
          state_d = ST_PEND;
          if (quo_next > DIV_W'(STEP_MAX)) begin
            result_d = STEP_MAX;
            err_d    = 1'b1;
          end else if (quo_next == '0) begin
            result_d = STEP_WIDTH'(1);
            err_d    = 1'b1;
          end else begin
            result_d = quo_next[STEP_WIDTH-1:0];
          end
        end
      end
      ST_PEND: begin
        if (vs_rise) begin
          step_d  = result_q;
          act_w_d = out_w_q;
          upd_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line-length monitor: count de per line, compare on hs rise outside vsync
  always_comb begin
    vs_d_d = vs_i;
    hs_d_d = hs_mon;
    cnt_d  = cnt_q;
    lerr_d = 1'b0;
    if (vs_i) begin
      cnt_d = '0;
    end else if (hs_rise) begin
      if ((cnt_q != '0) && (act_w_q != '0) && (cnt_q != {1'b0, act_w_q})) begin
        lerr_d = 1'b1;
      end
      cnt_d = CNT_W'(de_mon);
    end else if (de_mon && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_w_q  <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      result_q <= STEP_ONE;
      step_q   <= STEP_ONE;
      act_w_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      vs_d_q   <= 1'b0;
      hs_d_q   <= 1'b0;
      cnt_q    <= '0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_w_q  <= out_w_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      step_q   <= step_d;
      act_w_q  <= act_w_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      vs_d_q   <= vs_d_d;
      hs_d_q   <= hs_d_d;
      cnt_q    <= cnt_d;
      lerr_q   <= lerr_d;
    end
  end

  assign cfg_busy   = busy_q;
  assign cfg_err    = err_q;
  assign scale_step = step_q;
  assign step_upd   = upd_q;
  assign line_err   = lerr_q;

endmodule

// File: doc/scaler_h_step_ctrl.md
Name: scaler_h_step_ctrl

Overview:
- Configuration and sequencing controller for the horizontal scaler.
- Accepts software-programmed input and output line widths and computes the (4.12) unsigned `scale_step` with a sequential restoring divider.
- Holds the new step pending and applies it only at a frame boundary (rising edge of vs), so the scaler never changes ratio mid-frame.
- Monitors the scaler output stream and flags lines whose output pixel count differs from the programmed output width.

Parameters:
- W_WIDTH, 12, bit width of the line-width fields.
- FRAC_BITS, 12, fractional bits of scale_step (4096 = 1.0).
- STEP_WIDTH, 16, width of scale_step.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_in_w  in  W_WIDTH  input pixels per line
- cfg_out_w  in  W_WIDTH  requested output pixels per line
- cfg_wr  in  1  one-cycle strobe; captures cfg_in_w/cfg_out_w
- cfg_busy  out  1  high from accepted cfg_wr until the step is applied or rejected
- cfg_err  out  1  sticky error; cleared by the next accepted cfg_wr
- vs_i  in  1  scaler input vsync (level)
- de_mon  in  1  scaler de_o
- hs_mon  in  1  scaler hs_o
- scale_step  out  STEP_WIDTH  step driven to the scaler
- step_upd  out  1  one-cycle pulse in the cycle scale_step takes a new value
- line_err  out  1  one-cycle pulse on output line-length mismatch

Behaviour:

Reset:
- scale_step=1<<FRAC_BITS (4096); active out_w register=0.
- cfg_busy=0, cfg_err=0, step_upd=0, line_err=0.
- State=IDLE; pixel counter=0; vs/hs edge registers=0.
- A reset mid-division or in PEND aborts the operation; scale_step returns to 4096.

FSM IDLE / DIV / PEND:
- IDLE:
  - cfg_wr=1 captures both widths and clears cfg_err.
  - If cfg_out_w==0: cfg_err<=1, stay IDLE, cfg_busy stays 0, scale_step unchanged.
  - Otherwise go to DIV with cfg_busy<=1.
- DIV:
  - Restoring division of dividend {in_w, FRAC_BITS zeros} (W_WIDTH+FRAC_BITS = 24 bits) by out_w.
  - One quotient bit per cycle, MSB first; exactly W_WIDTH+FRAC_BITS cycles.
  - Quotient is floor(in_w*4096/out_w), computed in a 24-bit register.
  - On the last iteration go to PEND, holding the result:
    - If quotient > 2^STEP_WIDTH-1, the result saturates to 0xFFFF and cfg_err<=1.
    - If quotient == 0 (in_w==0), the result becomes 1 and cfg_err<=1.
- PEND:
  - Wait for the vs_i rising edge, detected as vs_i=1 and registered vs_d=0.
  - In the cycle after the edge is sampled: scale_step<=result, active out_w<=captured out_w, step_upd=1, cfg_busy<=0, go to IDLE.
  - If the edge coincides with the DIV→PEND transition, it is not honoured; the next vs edge applies the step.

Latency:
- Accepted cfg_wr at cycle 0 → DIV cycles 1..24 → PEND from cycle 25.
- Apply happens one cycle after the first vs rising edge sampled in PEND.

cfg_wr handling:
- cfg_wr while cfg_busy=1 is ignored: no capture, no error, result unaffected.

Line monitor:
- Counter counts cycles with de_mon=1; it is W_WIDTH+1 bits wide and saturates at all-ones.
- On the hs_mon rising edge: if counter≠0 and counter≠active out_w, line_err=1 for one cycle. The counter clears on the same edge.
- While vs_i=1 the counter clears and line_err is suppressed.
- If active out_w==0 (no configuration applied yet), the check is disabled.
- A de_mon=1 in the same cycle as the hs_mon edge counts toward the next line.

Test Plan:
- Normal downscale:
  - Stimulus: rst, then cfg_wr with in_w=1920, out_w=1280.
  - Required: cfg_busy=1 for cycles 1..25+; scale_step stays 4096 until the vs rise, then becomes 6144 with a single step_upd pulse; cfg_err=0.
- Upscale and back-to-back writes:
  - Stimulus: in_w=1280, out_w=1920 → after the vs edge, a second cfg_wr (in=640, out=640) issued mid-DIV.
  - Required: scale_step=2730; the second write is ignored.
  - Follow-up: repeat the 640/640 write after busy drops → step becomes 4096.
- Errors:
  - Stimulus: out_w=0.
  - Required: cfg_err=1 at the next cycle, cfg_busy never asserts, scale_step unchanged.
  - Stimulus: in_w=4095, out_w=200 (quotient 83865).
  - Required: applied step=65535, cfg_err=1; the next valid cfg_wr clears cfg_err.
- Vs timing:
  - Stimulus: vs_i held high continuously through PEND.
  - Required: no apply until vs falls and rises again.
  - Stimulus: vs rising edge at cycle 40.
  - Required: step_upd exactly at cycle 41.
- Line monitor (active out_w=1280):
  - Lines of 1280 de pulses → no line_err.
  - A line of 1279 → one line_err pulse at the hs_mon rising edge.
  - A zero-pixel line → no line_err.
  - Mismatched lines during vs_i=1 → no line_err.
- Reset mid-operation:
  - Stimulus: rst at DIV cycle 10, and separately in PEND.
  - Required: cfg_busy=0, scale_step=4096, no step_upd at the following vs edge.
